// File: rtl/stats_merge_avlstrm_pkg.sv
// Payload types shared by the stats packers, this merge block and the stats register block.
package stats_merge_avlstrm_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned VAL_W  = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [VAL_W-1:0]  val;
  } stats_t;

endpackage

// File: rtl/stats_merge_avlstrm.sv
// Merges NUM_IN single-beat stats_t update streams into one registered stream.
// One holding register per input, round-robin drain, and out-of-range addresses are dropped and counted.
module stats_merge_avlstrm
  import stats_merge_avlstrm_pkg::*;
#(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned NUM_REG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] stats_in_valid,
  output logic [NUM_IN-1:0] stats_in_ready,
  input  stats_t            stats_in_data [NUM_IN],
  output logic              stats_out_valid,
  input  logic              stats_out_ready,
  output logic              stats_out_sop,
  output logic              stats_out_eop,
  output stats_t            stats_out_data,
  output logic [31:0]       drop_cnt
);

  localparam int unsigned GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0] hold_full_q, hold_full_d;
  stats_t            hold_data_q [NUM_IN];
  stats_t            hold_data_d [NUM_IN];
  logic              out_valid_q, out_valid_d;
  stats_t            out_data_q, out_data_d;
  logic [31:0]       drop_cnt_q, drop_cnt_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;

  logic [NUM_IN-1:0] grant;
  logic [GW-1:0]     grant_idx;
  logic [GW-1:0]     idx;
  logic              found;
  logic              out_load;
  logic              accept;
  logic              in_range;
  logic [32:0]       drop_inc;
  logic [32:0]       drop_sum;

  // Round-robin search starting just after the last winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      idx = GW'((32'(last_grant_q) + k) % NUM_IN);
      if (!found && hold_full_q[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign out_load = found && (!out_valid_q || stats_out_ready);

  // Input accept, hold register update and drop counting.
  always_comb begin
    hold_full_d    = hold_full_q;
    hold_data_d    = hold_data_q;
    stats_in_ready = '0;
    accept         = 1'b0;
    in_range       = 1'b0;
    drop_inc       = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      stats_in_ready[i] = !hold_full_q[i] || (grant[i] && out_load);
      accept            = stats_in_valid[i] && stats_in_ready[i];
      in_range          = 32'(stats_in_data[i].addr) < NUM_REG;
      if (grant[i] && out_load) begin
        hold_full_d[i] = 1'b0;
      end
      if (accept && in_range) begin
        hold_full_d[i] = 1'b1;
        hold_data_d[i] = stats_in_data[i];
      end
      if (accept && !in_range) begin
        drop_inc = drop_inc + 33'd1;
      end
    end
    drop_sum   = 33'(drop_cnt_q) + drop_inc;
    drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
  end

  // Output register: load on a grant, otherwise release once the beat is taken.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    last_grant_d = last_grant_q;
    if (out_load) begin
      out_valid_d  = 1'b1;
      out_data_d   = hold_data_q[grant_idx];
      last_grant_d = grant_idx;
    end else if (out_valid_q && stats_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full_q  <= '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        hold_data_q[i] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      drop_cnt_q   <= '0;
      last_grant_q <= GW'(NUM_IN - 1);
    end else begin
      hold_full_q  <= hold_full_d;
      hold_data_q  <= hold_data_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      drop_cnt_q   <= drop_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Every beat is a complete packet, so sop/eop mirror valid.
  assign stats_out_valid = out_valid_q;
  assign stats_out_sop   = out_valid_q;
  assign stats_out_eop   = out_valid_q;
  assign stats_out_data  = out_data_q;
  assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_stats_merge_avlstrm.sv
// Scoreboard bench for stats_merge_avlstrm: directed scenarios plus a randomized run
// against per-input expected queues and a drop counter model.
module tb_stats_merge_avlstrm;
  import stats_merge_avlstrm_pkg::*;

  localparam int unsigned NUM_IN  = 4;
  localparam int unsigned NUM_REG = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_IN-1:0] in_valid;
  logic [NUM_IN-1:0] in_ready;
  stats_t            in_data [NUM_IN];
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;
  stats_t            out_data;
  logic [31:0]       drop_cnt;

  stats_merge_avlstrm #(.NUM_IN(NUM_IN), .NUM_REG(NUM_REG)) dut (
    .clk             (clk),
    .rst             (rst),
    .stats_in_valid  (in_valid),
    .stats_in_ready  (in_ready),
    .stats_in_data   (in_data),
    .stats_out_valid (out_valid),
    .stats_out_ready (out_ready),
    .stats_out_sop   (out_sop),
    .stats_out_eop   (out_eop),
    .stats_out_data  (out_data),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  int     vectors = 0;
  int     miscompares = 0;
  stats_t stim_q [NUM_IN][$];
  stats_t exp_q  [NUM_IN][$];
  int     out_src_log[$];
  int     out_cyc_log[$];
  int     acc_cnt [NUM_IN];
  int     last_acc_cyc = 0;
  longint exp_drop = 0;
  int     cyc = 0;
  bit     rnd_mode = 1'b0;
  bit     prev_stall = 1'b0;
  stats_t prev_data;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Driver: present the head of each stimulus queue on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      bit gate;
      gate = !rnd_mode || ($urandom_range(3) != 0);
      in_valid[i] = (stim_q[i].size() > 0) && gate;
      in_data[i]  = (stim_q[i].size() > 0) ? stim_q[i][0] : '0;
    end
    if (rnd_mode) out_ready = ($urandom_range(3) != 0);
  end

  // Monitor: score output beats, record accepts into the reference model.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid && out_ready) begin
        int found;
        check("out_sop", 64'(out_sop), 64'd1);
        check("out_eop", 64'(out_eop), 64'd1);
        found = -1;
        for (int i = 0; i < NUM_IN; i++)
          if (found < 0 && exp_q[i].size() > 0 && exp_q[i][0] == out_data) found = i;
        vectors++;
        if (found < 0) begin
          miscompares++;
          $display("FAIL out_data: got %0h, expected the head of some pending input queue", out_data);
        end else begin
          void'(exp_q[found].pop_front());
        end
        out_src_log.push_back(found);
        out_cyc_log.push_back(cyc);
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          void'(stim_q[i].pop_front());
          acc_cnt[i]++;
          last_acc_cyc = cyc;
          if (32'(in_data[i].addr) < NUM_REG) exp_q[i].push_back(in_data[i]);
          else if (exp_drop < 64'h0_FFFF_FFFF) exp_drop++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_model();
    for (int i = 0; i < NUM_IN; i++) begin
      stim_q[i].delete();
      exp_q[i].delete();
      acc_cnt[i] = 0;
    end
    out_src_log.delete();
    out_cyc_log.delete();
    exp_drop = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic wait_outs(input string name, input int n, input int bound);
    for (int k = 0; k < bound && out_src_log.size() < n; k++) @(negedge clk);
    #1 check(name, 64'(out_src_log.size() >= n), 64'd1);
  endtask

  function automatic stats_t mk(input int addr, input logic [31:0] val);
    stats_t s;
    s.addr = 8'(addr);
    s.val  = val;
    return s;
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_IN; i++) in_data[i] = '0;
    clear_model();
    repeat (2) @(negedge clk);

    // Reset state, both during and just after reset.
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_ready", 64'(in_ready), 64'hF);

    // Single update on input 2, two cycles of latency.
    reset_dut();
    @(posedge clk); #1 stim_q[2].push_back(mk(5, 32'hDEAD_BEEF));
    wait_outs("single_seen", 1, 20);
    if (out_src_log.size() > 0) begin
      check("single_src", 64'(out_src_log[0]), 64'd2);
      check("single_latency", 64'(out_cyc_log[0] - last_acc_cyc), 64'd2);
    end
    check("single_drop", 64'(drop_cnt), 64'd0);

    // Round robin: 4 beats per input, all held valid.
    reset_dut();
    @(posedge clk); #1;
    for (int i = 0; i < NUM_IN; i++)
      for (int k = 0; k < 4; k++) stim_q[i].push_back(mk(i * 4 + k, 32'h1000 * i + k));
    wait_outs("rr_seen", 16, 60);
    for (int k = 0; k < 16 && k < out_src_log.size(); k++)
      check($sformatf("rr_order%0d", k), 64'(out_src_log[k]), 64'(k % 4));
    for (int i = 0; i < NUM_IN; i++) check($sformatf("rr_acc%0d", i), 64'(acc_cnt[i]), 64'd4);

    // Backpressure: output stalled for 10 cycles, then drained.
    reset_dut();
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < NUM_IN; i++) stim_q[i].push_back(mk(10 + i, 32'hB000 + i));
    repeat (10) @(negedge clk);
    #1;
    check("bp_ready", 64'(in_ready[3:1]), 64'd0);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_none_out", 64'(out_src_log.size()), 64'd0);
    out_ready = 1'b1;
    wait_outs("bp_seen", 4, 20);
    for (int k = 0; k < 4 && k < out_src_log.size(); k++) begin
      check($sformatf("bp_order%0d", k), 64'(out_src_log[k]), 64'(k));
      if (k > 0) check($sformatf("bp_consec%0d", k), 64'(out_cyc_log[k] - out_cyc_log[k-1]), 64'd1);
    end

    // Drop filter: two out-of-range beats in one cycle, then one in-range beat.
    reset_dut();
    @(posedge clk); #1;
    stim_q[0].push_back(mk(NUM_REG, 32'hD0D0_0000));
    stim_q[0].push_back(mk(NUM_REG - 1, 32'hD0D0_0002));
    stim_q[1].push_back(mk(NUM_REG, 32'hD0D0_0001));
    repeat (8) @(negedge clk);
    #1;
    check("drop_cnt", 64'(drop_cnt), 64'd2);
    check("drop_outs", 64'(out_src_log.size()), 64'd1);
    if (out_src_log.size() > 0) check("drop_src", 64'(out_src_log[0]), 64'd0);

    // Back-to-back stream on input 3.
    reset_dut();
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) stim_q[3].push_back(mk(k, 32'h3300 + k));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      check($sformatf("b2b_ready%0d", k), 64'(in_ready[3]), 64'd1);
    end
    wait_outs("b2b_seen", 8, 20);
    for (int k = 1; k < 8 && k < out_src_log.size(); k++)
      check($sformatf("b2b_consec%0d", k), 64'(out_cyc_log[k] - out_cyc_log[k-1]), 64'd1);

    // Reset mid-run with three holds full and output valid.
    reset_dut();
    @(posedge clk); #1 stim_q[0].push_back(mk(NUM_REG + 3, 32'hEEEE_0000));
    repeat (3) @(negedge clk);
    #1 check("mid_drop_pre", 64'(drop_cnt), 64'd1);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < NUM_IN; i++) stim_q[i].push_back(mk(20 + i, 32'hAA00 + i));
    repeat (6) @(negedge clk);
    #1;
    check("mid_valid_pre", 64'(out_valid), 64'd1);
    check("mid_full_pre", 64'(in_ready[3:1]), 64'd0);
    rst = 1'b1;
    clear_model();
    #1;
    check("mid_valid_rst", 64'(out_valid), 64'd0);
    check("mid_drop_rst", 64'(drop_cnt), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("mid_no_stale", 64'(out_src_log.size()), 64'd0);
    @(posedge clk); #1;
    stim_q[3].push_back(mk(7, 32'h3333_0001));
    stim_q[0].push_back(mk(8, 32'h0000_0001));
    wait_outs("mid_seen", 2, 20);
    if (out_src_log.size() > 0) check("mid_first_grant", 64'(out_src_log[0]), 64'd0);

    // Randomized traffic with random gaps, random backpressure and random drops.
    reset_dut();
    rnd_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_IN; i++)
        if (stim_q[i].size() < 3 && $urandom_range(1) == 1)
          stim_q[i].push_back(mk(int'($urandom_range(NUM_REG + 7)), $urandom));
    end
    rnd_mode = 1'b0;
    @(negedge clk); #1 out_ready = 1'b1;
    begin
      bit busy;
      busy = 1'b1;
      for (int k = 0; k < 200 && busy; k++) begin
        @(negedge clk); #1;
        busy = 1'b0;
        for (int i = 0; i < NUM_IN; i++)
          if (stim_q[i].size() > 0 || exp_q[i].size() > 0) busy = 1'b1;
      end
      check("rnd_drained", 64'(busy), 64'd0);
    end
    check("rnd_drop", 64'(drop_cnt), 64'(exp_drop));
    check("rnd_idle", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
